// File: rtl/nand_seq_alu_pkg.sv
// Shared definitions for the bit-serial NAND sequencer: opcodes, states and
// the per-(op, step) gate operand schedule.
package nand_seq_alu_pkg;

    localparam logic [2:0] OP_NAND     = 3'd0;
    localparam logic [2:0] OP_NOT      = 3'd1;
    localparam logic [2:0] OP_AND      = 3'd2;
    localparam logic [2:0] OP_OR       = 3'd3;
    localparam logic [2:0] OP_XOR      = 3'd4;
    localparam logic [2:0] OP_RSVD_MIN = 3'd5;

    // Gate evaluations per result bit for each opcode
    localparam int STEPS_NAND = 1;
    localparam int STEPS_NOT  = 1;
    localparam int STEPS_AND  = 2;
    localparam int STEPS_OR   = 3;
    localparam int STEPS_XOR  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Gate input sources and result destinations
    typedef enum logic [1:0] { SRC_A, SRC_B, SRC_T1, SRC_T2 } src_t;
    typedef enum logic [1:0] { DST_T1, DST_T2, DST_OUT } dst_t;

    typedef struct packed {
        src_t x;
        src_t y;
        dst_t dst;
        logic last;   // final step of the current bit
    } step_ctl_t;

    function automatic logic is_rsvd(input logic [2:0] op);
        return op >= OP_RSVD_MIN;
    endfunction

    // Operand schedule: which scratch/operand bits feed the gate and where
    // its output lands, for every (op, step) pair.
    function automatic step_ctl_t step_ctl(input logic [2:0] op, input logic [1:0] step);
        step_ctl_t c;
        c = '{x: SRC_A, y: SRC_B, dst: DST_OUT, last: 1'b1};
        case (op)
            OP_NOT:  c = '{x: SRC_A, y: SRC_A, dst: DST_OUT, last: 1'b1};
            OP_AND:
                if (step == 2'd0) c = '{x: SRC_A,  y: SRC_B,  dst: DST_T1,  last: 1'b0};
                else              c = '{x: SRC_T1, y: SRC_T1, dst: DST_OUT, last: 1'b1};
            OP_OR:
                case (step)
                    2'd0:    c = '{x: SRC_A,  y: SRC_A,  dst: DST_T1,  last: 1'b0};
                    2'd1:    c = '{x: SRC_B,  y: SRC_B,  dst: DST_T2,  last: 1'b0};
                    default: c = '{x: SRC_T1, y: SRC_T2, dst: DST_OUT, last: 1'b1};
                endcase
            OP_XOR:
                case (step)
                    2'd0:    c = '{x: SRC_A,  y: SRC_B,  dst: DST_T1,  last: 1'b0};
                    2'd1:    c = '{x: SRC_A,  y: SRC_T1, dst: DST_T2,  last: 1'b0};
                    2'd2:    c = '{x: SRC_B,  y: SRC_T1, dst: DST_T1,  last: 1'b0};
                    default: c = '{x: SRC_T2, y: SRC_T1, dst: DST_OUT, last: 1'b1};
                endcase
            default: c = '{x: SRC_A, y: SRC_B, dst: DST_OUT, last: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/nand_seq_alu_g_nand.sv
// The single elementary NAND gate shared by every composite operation.
module nand_seq_alu_g_nand (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/nand_seq_alu.sv
// Bit-serial logic unit: schedules one shared NAND gate, one evaluation per
// cycle, LSB first, behind a valid/ready request/response handshake.
module nand_seq_alu
    import nand_seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_err,
    output logic             busy
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, result;
    logic [2:0]       op_q;
    logic [BW-1:0]    bit_idx;
    logic [1:0]       step;
    logic             t1, t2, err;
    step_ctl_t        ctl;
    logic             gx, gy, gz;
    logic             last_bit;

    assign last_bit  = (bit_idx == BW'(WIDTH - 1));
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign rsp_out   = result;
    assign rsp_err   = err;

    // Gate operand mux selected by (op, step)
    always_comb begin
        ctl = step_ctl(op_q, step);
        gx  = 1'b0;
        gy  = 1'b0;
        case (ctl.x)
            SRC_A:   gx = a_q[bit_idx];
            SRC_B:   gx = b_q[bit_idx];
            SRC_T1:  gx = t1;
            default: gx = t2;
        endcase
        case (ctl.y)
            SRC_A:   gy = a_q[bit_idx];
            SRC_B:   gy = b_q[bit_idx];
            SRC_T1:  gy = t1;
            default: gy = t2;
        endcase
    end

    nand_seq_alu_g_nand g_NAND (
        .a (gx),
        .b (gy),
        .y (gz)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: reserved opcodes skip EVAL entirely
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = is_rsvd(req_op) ? ST_DONE : ST_EVAL;
            ST_EVAL: if (ctl.last && last_bit) state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, step/bit counters, scratch bits and result insertion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            bit_idx <= '0;
            step    <= '0;
            t1      <= 1'b0;
            t2      <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    a_q     <= req_a;
                    b_q     <= req_b;
                    op_q    <= req_op;
                    bit_idx <= '0;
                    step    <= '0;
                    t1      <= 1'b0;
                    t2      <= 1'b0;
                    result  <= '0;
                    err     <= is_rsvd(req_op);
                end
                ST_EVAL: begin
                    case (ctl.dst)
                        DST_T1:  t1 <= gz;
                        DST_T2:  t2 <= gz;
                        default: result[bit_idx] <= gz;
                    endcase
                    if (ctl.last) begin
                        step <= '0;
                        if (!last_bit) bit_idx <= bit_idx + BW'(1);
                    end else begin
                        step <= step + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_seq_alu.sv
// Bench for nand_seq_alu: countdown-based behavioural model checked every
// cycle, plus directed scenarios with literal expectations and random traffic.
module tb_nand_seq_alu;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = '0;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_out;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int failures = 0;

    nand_seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics in plain arithmetic
    function automatic logic [W-1:0] ref_out(input logic [2:0] op, input logic [W-1:0] a, b);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return ~a;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    function automatic int ref_steps(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 1;
            3'd2:       return 2;
            3'd3:       return 3;
            3'd4:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Model: a busy flag with a countdown of remaining evaluation cycles
    bit           mdl_busy;
    int           mdl_cnt;
    logic [W-1:0] mdl_out;
    logic         mdl_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
            mdl_out  <= '0;
            mdl_err  <= 1'b0;
        end else if (!mdl_busy) begin
            if (req_valid) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= W * ref_steps(req_op);
                mdl_out  <= ref_out(req_op, req_a, req_b);
                mdl_err  <= (ref_steps(req_op) == 0);
            end
        end else if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (rsp_ready) begin
            mdl_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_req_ready", req_ready, !mdl_busy);
            chk("cyc_busy", busy, mdl_busy);
            chk("cyc_rsp_valid", rsp_valid, mdl_busy && mdl_cnt == 0);
            if (mdl_busy && mdl_cnt == 0) begin
                chk("cyc_rsp_out", rsp_out, mdl_out);
                chk("cyc_rsp_err", rsp_err, mdl_err);
            end
        end
    end

    // Issue one request, measure edges after accept until rsp_valid, then
    // optionally stall the response for bp cycles before taking it.
    task automatic do_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int bp, input bit pulse,
                          output int lat, output logic [W-1:0] out, output logic err);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = W'($urandom);
        req_b = W'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("rsp_valid_wait", rsp_valid, 1);
        out = rsp_out;
        err = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_out", rsp_out, out);
            chk("bp_err", rsp_err, err);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_busy", busy, 1);
            chk("bp_req_ready", req_ready, 0);
            if (pulse && i == 4) begin
                req_valid = 1'b1;
                req_op = 3'd0;
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] out;
        logic err;
        logic [W-1:0] pa [5];
        logic [W-1:0] pb [5];
        logic [2:0] rop;
        logic [W-1:0] ra, rb;

        pa = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hCCCC};
        pb = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hAAAA};

        #12 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_out", rsp_out, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);

        // XOR
        do_req(3'd4, 16'hF0F0, 16'hFF00, 0, 0, lat, out, err);
        chk("xor_out", out, 16'h0FF0);
        chk("xor_err", err, 0);
        chk("xor_lat", lat, 64);

        // OR then NOT back-to-back
        do_req(3'd3, 16'h1234, 16'h00FF, 0, 0, lat, out, err);
        chk("or_out", out, 16'h12FF);
        chk("or_lat", lat, 48);
        do_req(3'd1, 16'hA5A5, 16'h1357, 0, 0, lat, out, err);
        chk("not_out", out, 16'h5A5A);
        chk("not_lat", lat, 16);

        // Reserved opcode, then a normal request
        do_req(3'd6, 16'hBEEF, 16'hCAFE, 0, 0, lat, out, err);
        chk("rsvd_lat", lat, 0);
        chk("rsvd_err", err, 1);
        chk("rsvd_out", out, 0);

        // AND with 10 cycles of backpressure and an ignored req_valid pulse
        do_req(3'd2, 16'hFFFF, 16'h8001, 10, 1, lat, out, err);
        chk("and_out", out, 16'h8001);
        chk("and_err", err, 0);
        chk("and_lat", lat, 32);

        // Reset in the middle of bit 7 of an XOR
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 3'd4;
        req_a = 16'h1234;
        req_b = 16'h5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_out", rsp_out, 0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        do_req(3'd0, 16'h00FF, 16'h0F0F, 0, 0, lat, out, err);
        chk("nand_out", out, 16'hFFF0);
        chk("nand_lat", lat, 16);

        // All bit-pair patterns for every valid opcode
        for (int op = 0; op < 5; op++) begin
            for (int p = 0; p < 5; p++) begin
                do_req(3'(op), pa[p], pb[p], 0, 0, lat, out, err);
                chk("pat_out", out, ref_out(3'(op), pa[p], pb[p]));
                chk("pat_err", err, 0);
                chk("pat_lat", lat, W * ref_steps(3'(op)));
            end
        end

        // Random traffic including reserved opcodes and random stalls
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = W'($urandom);
            rb  = W'($urandom);
            do_req(rop, ra, rb, $urandom_range(0, 3), 0, lat, out, err);
            chk("rnd_out", out, ref_out(rop, ra, rb));
            chk("rnd_err", err, ref_steps(rop) == 0);
            chk("rnd_lat", lat, W * ref_steps(rop));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
